fp_normalize_pipe: RTL and testbench

Parametrised, pipelined post-add normaliser for the floating adder datapath. It takes the raw significand sum, carry, sign and pre-normalisation exponent from the adder core and produces a normalised fraction and adjusted exponent. It generalises the combinational normaliser in three ways: configurable widths, denormal/overflow/zero handling, and a 2-stage valid/ready pipeline. It sits between the significand adder and the result packer.

---
 rtl/fp_norm_pkg.sv | 19 +
 rtl/leading_zero_counter.sv | 22 ++
 rtl/fp_normalize_pipe.sv | 145 ++++++++++++++
 tb/tb_fp_normalize_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared types and helpers for the post-add normaliser.
// Provides default widths, the exponent saturation value, and the result flag bundle.
package fp_norm_pkg;

    localparam int DEFAULT_MANT_W = 23;
    localparam int DEFAULT_EXP_W  = 8;

    // All-ones biased exponent (infinity/NaN encoding) for a field of width w
    function automatic logic [31:0] exp_all_ones(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    typedef struct packed {
        logic zero;
        logic underflow;
        logic overflow;
    } norm_flags_t;

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero counter.
// The count is measured from the MSB and is W when the input is all zero.
module leading_zero_counter #(
    parameter int W = 24
) (
    input  logic [W-1:0]             value,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int CW = $clog2(W+1);

    // Scan upward so the highest set bit is the last one to write the count
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage pipelined normaliser between the significand adder and the result packer.
// Stage 1 captures the raw sum and its leading-zero count; stage 2 shifts and adjusts the exponent.
module fp_normalize_pipe
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = DEFAULT_MANT_W,
    parameter int EXP_W  = DEFAULT_EXP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W:0]   in_mant,
    input  logic              in_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_frac,
    output logic              out_zero,
    output logic              out_underflow,
    output logic              out_overflow
);

    localparam int LZ_W = $clog2(MANT_W + 2);
    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(exp_all_ones(EXP_W));

    // Handshake: a beat moves across a boundary on a cycle where valid && ready.
    // Stage 2 loads when empty or drained by out_ready; stage 1 loads when empty
    // or when stage 2 is loading. in_ready never looks at in_valid.
    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [MANT_W:0]   s1_mant;
    logic              s1_carry;
    logic [LZ_W-1:0]   s1_lz;
    logic [LZ_W-1:0]   in_lz;

    leading_zero_counter #(.W(MANT_W + 1)) u_lzc (
        .value (in_mant),
        .count (in_lz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_sign  <= in_sign;
            s1_exp   <= in_exp;
            s1_mant  <= in_mant;
            s1_carry <= in_carry;
            s1_lz    <= in_lz;
        end
    end

    // Exponent math is one bit wider than the field so it can never wrap
    logic [EXP_W:0] e_ext;
    logic [EXP_W:0] lz_ext;
    logic [EXP_W:0] e_inc;
    logic [EXP_W:0] e_sub;
    logic [EXP_W:0] e_dec;

    assign e_ext  = {1'b0, s1_exp};
    assign lz_ext = (EXP_W + 1)'(s1_lz);
    assign e_inc  = e_ext + 1'b1;
    assign e_sub  = e_ext - lz_ext;
    assign e_dec  = e_ext - 1'b1;

    logic [EXP_W-1:0]  nx_exp;
    logic [MANT_W-1:0] nx_frac;
    norm_flags_t       nx_flags;
    logic [MANT_W:0]   shifted;

    always_comb begin
        nx_exp   = '0;
        nx_frac  = '0;
        nx_flags = '0;
        shifted  = '0;
        if (s1_carry) begin
            if (s1_exp == EXP_MAX || e_inc == {1'b0, EXP_MAX}) begin
                nx_exp            = EXP_MAX;
                nx_flags.overflow = 1'b1;
            end else begin
                nx_exp  = e_inc[EXP_W-1:0];
                nx_frac = s1_mant[MANT_W:1];
            end
        end else if (s1_mant == '0) begin
            nx_flags.zero = 1'b1;
        end else if (e_ext > lz_ext) begin
            shifted = s1_mant << lz_ext;
            nx_frac = shifted[MANT_W-1:0];
            nx_exp  = e_sub[EXP_W-1:0];
        end else if (s1_exp != '0) begin
            // Only enough shift to land on the minimum exponent; result is denormal
            shifted            = s1_mant << e_dec;
            nx_frac            = shifted[MANT_W-1:0];
            nx_flags.underflow = 1'b1;
        end else begin
            nx_frac            = s1_mant[MANT_W-1:0];
            nx_flags.underflow = 1'b1;
        end
    end

    norm_flags_t out_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_frac  <= '0;
            out_flags <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign  <= s1_sign;
                out_exp   <= nx_exp;
                out_frac  <= nx_frac;
                out_flags <= nx_flags;
            end
        end
    end

    assign out_zero      = out_flags.zero;
    assign out_underflow = out_flags.underflow;
    assign out_overflow  = out_flags.overflow;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed bench for fp_normalize_pipe at the default 23/8 widths.
// Results are packed as {sign, exp, frac, zero, underflow, overflow} and scoreboarded in order.
module tb_fp_normalize_pipe;

  localparam int MANT_W = 23;
  localparam int EXP_W  = 8;
  localparam int RES_W  = 1 + EXP_W + MANT_W + 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W:0]   in_mant;
  logic              in_carry;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-1:0] out_frac;
  logic              out_zero;
  logic              out_underflow;
  logic              out_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int n_results = 0;
  logic [RES_W-1:0] exp_q[$];

  fp_normalize_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .in_carry      (in_carry),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sign      (out_sign),
    .out_exp       (out_exp),
    .out_frac      (out_frac),
    .out_zero      (out_zero),
    .out_underflow (out_underflow),
    .out_overflow  (out_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [RES_W-1:0] mk(input logic s, input logic [7:0] e, input logic [22:0] f,
                                          input logic z, input logic u, input logic o);
    return {s, e, f, z, u, o};
  endfunction

  function automatic logic [RES_W-1:0] observed();
    return {out_sign, out_exp, out_frac, out_zero, out_underflow, out_overflow};
  endfunction

  // driver: call at posedge+1; leaves in_valid high so beats can stream back to back
  task automatic drive(input logic s, input logic [7:0] e, input logic [23:0] m,
                       input logic c, input logic [RES_W-1:0] expected);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_carry = c;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) exp_q.push_back(expected);
    else check("accept_timeout", 64'(acc), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard / monitor, sampled on the falling edge
  logic             held_pending = 1'b0;
  logic [RES_W-1:0] held_val;

  always @(negedge clk) begin
    if (rst_n) begin
      if (held_pending && out_valid) check("hold", 64'(observed()), 64'(held_val));
      if (out_valid && out_ready) begin
        n_results++;
        if (exp_q.size() == 0) check("unexpected_beat", 64'(observed()), 64'd0);
        else check("result", 64'(observed()), 64'(exp_q.pop_front()));
      end
      held_pending = out_valid && !out_ready;
      held_val     = observed();
    end else begin
      held_pending = 1'b0;
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_carry  = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'(observed()), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // already normalised, with latency check
    drive(1'b0, 8'd127, 24'h800000, 1'b0, mk(0, 8'd127, 23'h0, 0, 0, 0));
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_2", 64'(out_valid), 64'd1);
    idle(2);

    // carry, overflow, shifts, underflow and denormal inputs streamed back to back
    drive(1'b0, 8'd127, 24'h400000, 1'b1, mk(0, 8'd128, 23'h200000, 0, 0, 0));
    drive(1'b0, 8'd254, 24'h800000, 1'b1, mk(0, 8'hFF, 23'h0, 0, 0, 1));
    drive(1'b0, 8'd255, 24'h123456, 1'b1, mk(0, 8'hFF, 23'h0, 0, 0, 1));
    drive(1'b0, 8'd253, 24'hFFFFFF, 1'b1, mk(0, 8'd254, 23'h7FFFFF, 0, 0, 0));
    drive(1'b0, 8'd100, 24'h000001, 1'b0, mk(0, 8'd77, 23'h0, 0, 0, 0));
    drive(1'b1, 8'd20,  24'h0F0000, 1'b0, mk(1, 8'd16, 23'h700000, 0, 0, 0));
    drive(1'b0, 8'd10,  24'h000100, 1'b0, mk(0, 8'd0, 23'h020000, 0, 1, 0));
    drive(1'b0, 8'd15,  24'h000100, 1'b0, mk(0, 8'd0, 23'h400000, 0, 1, 0));
    drive(1'b0, 8'd16,  24'h000100, 1'b0, mk(0, 8'd1, 23'h0, 0, 0, 0));
    drive(1'b0, 8'd0,   24'h000123, 1'b0, mk(0, 8'd0, 23'h000123, 0, 1, 0));
    drive(1'b0, 8'd0,   24'h800001, 1'b0, mk(0, 8'd0, 23'h000001, 0, 1, 0));
    drive(1'b1, 8'd0,   24'h000000, 1'b0, mk(1, 8'd0, 23'h0, 1, 0, 0));
    drive(1'b1, 8'd50,  24'h000000, 1'b0, mk(1, 8'd0, 23'h0, 1, 0, 0));
    idle(4);
    check("drain_1", 64'(exp_q.size()), 64'd0);

    // backpressure: out_ready low for 3 cycles while 4 beats stream in
    fork
      begin
        drive(1'b0, 8'd1,   24'h800000, 1'b0, mk(0, 8'd1, 23'h0, 0, 0, 0));
        drive(1'b0, 8'd5,   24'h600000, 1'b0, mk(0, 8'd4, 23'h400000, 0, 0, 0));
        drive(1'b0, 8'd200, 24'h000005, 1'b0, mk(0, 8'd179, 23'h200000, 0, 0, 0));
        drive(1'b1, 8'd3,   24'h000001, 1'b1, mk(1, 8'd4, 23'h0, 0, 0, 0));
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_0", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("bp_ready_1", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("bp_ready_full", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(5);
    check("drain_2", 64'(exp_q.size()), 64'd0);
    check("result_count", 64'(n_results), 64'd18);

    // reset mid-stream discards the in-flight beat
    drive(1'b0, 8'd127, 24'h800000, 1'b0, mk(0, 8'd127, 23'h0, 0, 0, 0));
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_outputs", 64'(observed()), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_quiet", 64'(out_valid), 64'd0);
    check("midrst_count", 64'(n_results), 64'd18);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
